// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
// Optional mult/div support (func 0x18/0x1A, MULDIV state) is enabled by defining MC_CU_MULDIV_EN.
module mc_control_unit #(
    parameter int unsigned ALUOP_W       = 6,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned MULDIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PCSource,
    output logic               ALUsrcA,
    output logic [1:0]         ALUsrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegDest,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               jalCtrl,
    output logic               illegal,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnSys = 6'h0C;
`ifdef MC_CU_MULDIV_EN
    localparam logic [5:0] FnMult = 6'h18;
    localparam logic [5:0] FnDiv  = 6'h1A;
    localparam int unsigned MdCntW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
`endif

    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(6'h20);
    localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(6'h22);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
`ifdef MC_CU_MULDIV_EN
        , StMulDiv
`endif
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               w_retire;
    logic [CNT_W-1:0]   r_retired;
    logic               w_is_rtype;
    logic               w_op_legal;
    logic               w_func_legal;
    logic               w_legal;
    logic               w_is_jr;
    logic               w_is_sys;
    logic [ALUOP_W-1:0] w_alu_func;
`ifdef MC_CU_MULDIV_EN
    logic               w_is_md;
    logic [MdCntW-1:0]  r_md_cnt;
`else
    logic               w_unused_md;
    assign w_unused_md = ^MULDIV_CYCLES;
`endif

    assign w_is_rtype = (opcode == OpRtype);
    assign w_is_jr    = w_is_rtype && (func == FnJr);
    assign w_is_sys   = w_is_rtype && (func == FnSys);
    assign w_alu_func = ALUOP_W'(func);
`ifdef MC_CU_MULDIV_EN
    assign w_is_md    = w_is_rtype && ((func == FnMult) || (func == FnDiv));
`endif

    always_comb begin
        case (opcode)
            OpRtype, OpJ, OpJal, OpBeq, OpBne, OpAddi, OpLw, OpSw: w_op_legal = 1'b1;
            default:                                               w_op_legal = 1'b0;
        endcase
        case (func)
            FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnJr, FnSys: w_func_legal = 1'b1;
`ifdef MC_CU_MULDIV_EN
            FnMult, FnDiv:                                 w_func_legal = 1'b1;
`endif
            default:                                       w_func_legal = 1'b0;
        endcase
    end

    assign w_legal = w_op_legal && (!w_is_rtype || w_func_legal);

    always_comb begin
        w_state_d = r_state;
        w_retire  = 1'b0;
        case (r_state)
            StFetch:  if (mem_ready) w_state_d = StDecode;
            StDecode: w_state_d = w_legal ? StExec : StFetch;
            StExec: begin
                if (w_is_rtype) begin
                    if (w_is_jr) begin
                        w_retire  = 1'b1;
                        w_state_d = StFetch;
                    end else if (w_is_sys) begin
                        w_retire  = 1'b1;
                        w_state_d = StHalt;
`ifdef MC_CU_MULDIV_EN
                    end else if (w_is_md) begin
                        w_state_d = StMulDiv;
`endif
                    end else begin
                        w_state_d = StWb;
                    end
                end else if (opcode == OpLw || opcode == OpSw) begin
                    w_state_d = StMem;
                end else if (opcode == OpAddi) begin
                    w_state_d = StWb;
                end else begin
                    // beq/bne/j/jal complete in EXEC
                    w_retire  = 1'b1;
                    w_state_d = StFetch;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    if (opcode == OpSw) begin
                        w_retire  = 1'b1;
                        w_state_d = StFetch;
                    end else begin
                        w_state_d = StWb;
                    end
                end
            end
            StWb: begin
                w_retire  = 1'b1;
                w_state_d = StFetch;
            end
            StHalt: w_state_d = StHalt;
`ifdef MC_CU_MULDIV_EN
            StMulDiv: begin
                if (r_md_cnt == '0) begin
                    w_retire  = 1'b1;
                    w_state_d = StFetch;
                end
            end
`endif
            default: w_state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StFetch;
            r_retired <= '0;
`ifdef MC_CU_MULDIV_EN
            r_md_cnt  <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
`ifdef MC_CU_MULDIV_EN
            if (r_state == StExec && w_state_d == StMulDiv) begin
                r_md_cnt <= MdCntW'(MULDIV_CYCLES - 1);
            end else if (r_state == StMulDiv && r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - MdCntW'(1);
            end
`endif
        end
    end

    assign retired = r_retired;

    // Outputs are forced low while reset is asserted so mem_req drops asynchronously.
    always_comb begin
        mem_req  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSource = 2'd0;
        ALUsrcA  = 1'b0;
        ALUsrcB  = 2'd0;
        ALUOp    = '0;
        RegDest  = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        jalCtrl  = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        if (rst_n) begin
            case (r_state)
                StFetch: begin
                    mem_req = 1'b1;
                    ALUsrcB = 2'd1;
                    ALUOp   = AluAdd;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                StDecode: begin
                    ALUsrcB = 2'd3;
                    ALUOp   = AluAdd;
                    illegal = !w_legal;
                end
                StExec: begin
                    if (w_is_rtype) begin
                        ALUsrcA = 1'b1;
                        ALUOp   = w_alu_func;
                        if (w_is_jr) begin
                            PCWrite  = 1'b1;
                            PCSource = 2'd3;
                        end
                    end else if (opcode == OpLw || opcode == OpSw || opcode == OpAddi) begin
                        ALUsrcA = 1'b1;
                        ALUsrcB = 2'd2;
                        ALUOp   = AluAdd;
                    end else if (opcode == OpBeq || opcode == OpBne) begin
                        ALUsrcA  = 1'b1;
                        ALUOp    = AluSub;
                        PCSource = 2'd1;
                        PCWrite  = zero ^ (opcode == OpBne);
                    end else begin
                        PCWrite  = 1'b1;
                        PCSource = 2'd2;
                        jalCtrl  = (opcode == OpJal);
                        RegWrite = (opcode == OpJal);
                    end
                end
                StMem: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = (opcode == OpSw);
                end
                StWb: begin
                    RegWrite = 1'b1;
                    RegDest  = w_is_rtype;
                    MemToReg = (opcode == OpLw);
                end
                StHalt: halted = 1'b1;
`ifdef MC_CU_MULDIV_EN
                StMulDiv: ALUOp = w_alu_func;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit (default build, CNT_W=4 so the counter wrap is reachable).
module tb_mc_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [5:0] ALUOp;
    logic       RegDest;
    logic       MemToReg;
    logic       RegWrite;
    logic       jalCtrl;
    logic       illegal;
    logic       halted;
    logic [3:0] retired;

    int n_checks;
    int n_errors;

    mc_control_unit #(
        .ALUOP_W       (6),
        .CNT_W         (4),
        .MULDIV_CYCLES (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .func      (func),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCSource  (PCSource),
        .ALUsrcA   (ALUsrcA),
        .ALUsrcB   (ALUsrcB),
        .ALUOp     (ALUOp),
        .RegDest   (RegDest),
        .MemToReg  (MemToReg),
        .RegWrite  (RegWrite),
        .jalCtrl   (jalCtrl),
        .illegal   (illegal),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs on the falling edge and let the Moore outputs settle before checking.
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        @(negedge clk);
        opcode    = op;
        func      = fn;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        opcode    = '0;
        func      = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // add: F D E WB
        cyc(6'h00, 6'h20, 0, 1);
        check("add_f_req", mem_req, 1);
        check("add_f_irw", IRWrite, 1);
        check("add_f_pcw", PCWrite, 1);
        check("add_f_srcb", ALUsrcB, 1);
        check("add_f_aluop", ALUOp, 6'h20);
        cyc(6'h00, 6'h20, 0, 1);
        check("add_d_srcb", ALUsrcB, 3);
        check("add_d_ill", illegal, 0);
        check("add_d_req", mem_req, 0);
        cyc(6'h00, 6'h20, 0, 1);
        check("add_e_srca", ALUsrcA, 1);
        check("add_e_srcb", ALUsrcB, 0);
        check("add_e_rw", RegWrite, 0);
        cyc(6'h00, 6'h20, 0, 1);
        check("add_wb_rw", RegWrite, 1);
        check("add_wb_rd", RegDest, 1);
        check("add_wb_m2r", MemToReg, 0);

        // lw with three MEM stall cycles: 8 cycles total
        cyc(6'h23, 6'h00, 0, 1);
        check("lw_f_retired", retired, 1);
        check("lw_f_req", mem_req, 1);
        cyc(6'h23, 6'h00, 0, 1);
        cyc(6'h23, 6'h00, 0, 1);
        check("lw_e_srcb", ALUsrcB, 2);
        for (int i = 0; i < 4; i++) begin
            cyc(6'h23, 6'h00, 0, (i == 3));
            check("lw_mem_iord", IorD, 1);
            check("lw_mem_req", mem_req, 1);
            check("lw_mem_mw", MemWrite, 0);
        end
        cyc(6'h23, 6'h00, 0, 1);
        check("lw_wb_rw", RegWrite, 1);
        check("lw_wb_m2r", MemToReg, 1);
        check("lw_wb_rd", RegDest, 0);
        check("lw_wb_retired", retired, 1);

        // sw with one FETCH stall
        cyc(6'h2B, 6'h00, 0, 0);
        check("sw_fstall_retired", retired, 2);
        check("sw_fstall_req", mem_req, 1);
        check("sw_fstall_irw", IRWrite, 0);
        check("sw_fstall_pcw", PCWrite, 0);
        cyc(6'h2B, 6'h00, 0, 1);
        check("sw_f_irw", IRWrite, 1);
        cyc(6'h2B, 6'h00, 0, 1);
        cyc(6'h2B, 6'h00, 0, 1);
        check("sw_e_srcb", ALUsrcB, 2);
        cyc(6'h2B, 6'h00, 0, 1);
        check("sw_mem_mw", MemWrite, 1);
        check("sw_mem_iord", IorD, 1);

        // beq taken
        cyc(6'h04, 6'h00, 1, 1);
        check("beq_f_retired", retired, 3);
        check("beq_f_iord", IorD, 0);
        cyc(6'h04, 6'h00, 1, 1);
        cyc(6'h04, 6'h00, 1, 1);
        check("beq_e_pcw", PCWrite, 1);
        check("beq_e_pcs", PCSource, 1);
        check("beq_e_aluop", ALUOp, 6'h22);

        // bne with zero=1: not taken
        cyc(6'h05, 6'h00, 1, 1);
        check("bne_f_retired", retired, 4);
        cyc(6'h05, 6'h00, 1, 1);
        cyc(6'h05, 6'h00, 1, 1);
        check("bne_e_pcw", PCWrite, 0);

        // jal
        cyc(6'h03, 6'h00, 0, 1);
        check("jal_f_retired", retired, 5);
        cyc(6'h03, 6'h00, 0, 1);
        cyc(6'h03, 6'h00, 0, 1);
        check("jal_e_pcw", PCWrite, 1);
        check("jal_e_pcs", PCSource, 2);
        check("jal_e_jal", jalCtrl, 1);
        check("jal_e_rw", RegWrite, 1);

        // jr
        cyc(6'h00, 6'h08, 0, 1);
        check("jr_f_retired", retired, 6);
        cyc(6'h00, 6'h08, 0, 1);
        cyc(6'h00, 6'h08, 0, 1);
        check("jr_e_pcw", PCWrite, 1);
        check("jr_e_pcs", PCSource, 3);

        // illegal opcode, then illegal func (mult without the optional feature)
        cyc(6'h3F, 6'h00, 0, 1);
        check("ill_f_retired", retired, 7);
        cyc(6'h3F, 6'h00, 0, 1);
        check("ill_op_pulse", illegal, 1);
        cyc(6'h00, 6'h18, 0, 1);
        check("ill_back_fetch", mem_req, 1);
        check("ill_pulse_end", illegal, 0);
        check("ill_retired", retired, 7);
        cyc(6'h00, 6'h18, 0, 1);
        check("ill_fn_pulse", illegal, 1);

        // addi
        cyc(6'h08, 6'h00, 0, 1);
        check("addi_f_retired", retired, 7);
        cyc(6'h08, 6'h00, 0, 1);
        cyc(6'h08, 6'h00, 0, 1);
        check("addi_e_srcb", ALUsrcB, 2);
        cyc(6'h08, 6'h00, 0, 1);
        check("addi_wb_rw", RegWrite, 1);
        check("addi_wb_rd", RegDest, 0);

        // reset asserted mid-MEM
        cyc(6'h23, 6'h00, 0, 1);
        check("rmem_f_retired", retired, 8);
        cyc(6'h23, 6'h00, 0, 1);
        cyc(6'h23, 6'h00, 0, 1);
        cyc(6'h23, 6'h00, 0, 0);
        check("rmem_req_before", mem_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rmem_req_async", mem_req, 0);
        check("rmem_iord_async", IorD, 0);
        check("rmem_retired", retired, 0);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 15 jumps bring the 4-bit counter to max, the 16th wraps it
        for (int n = 0; n < 16; n++) begin
            cyc(6'h02, 6'h00, 0, 1);
            if (n == 0) begin
                check("post_rst_fetch", mem_req, 1);
                check("post_rst_retired", retired, 0);
            end
            if (n == 15) check("cnt_max", retired, 15);
            cyc(6'h02, 6'h00, 0, 1);
            cyc(6'h02, 6'h00, 0, 1);
            check("j_e_pcs", PCSource, 2);
        end

        // syscall: halt is absorbing and never requests memory
        cyc(6'h00, 6'h0C, 0, 1);
        check("cnt_wrap", retired, 0);
        cyc(6'h00, 6'h0C, 0, 1);
        cyc(6'h00, 6'h0C, 0, 1);
        check("sys_e_halted", halted, 0);
        for (int k = 0; k < 20; k++) begin
            cyc(6'h23, 6'h20, 0, 1);
            check("halt_state", {halted, mem_req}, 2'b10);
        end
        check("halt_retired", retired, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- FSM sequences fetch, decode, execute, memory and writeback per instruction.
- Drives datapath enables every cycle and talks to a shared instruction/data memory through a req/ready handshake.
- Counts retired instructions; sits between the instruction register and the multi-cycle datapath.

Parameters:
- ALUOP_W, 6, ALU operation code width; R-type passes func through, zero-extended or truncated to ALUOP_W.
- CNT_W, 32, width of the retired-instruction counter.
- MULDIV_CYCLES, 8, busy cycles for mult/div; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag, sampled in EXEC for branches.
- mem_ready  in  1  memory completed current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- MemWrite  out  1  write qualifier for mem_req.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  unconditional PC load.
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register rs (jr).
- ALUsrcA  out  1  0 = PC, 1 = rs.
- ALUsrcB  out  2  0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = imm<<2.
- ALUOp  out  ALUOP_W  ALU operation.
- RegDest  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- jalCtrl  out  1  write PC+4 to $31.
- illegal  out  1  one-cycle pulse on unknown opcode/func.
- halted  out  1  sticky after syscall.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous, rst_n=0): state=FETCH, retired=0, halted=0, all outputs 0. Reset mid-transfer drops mem_req immediately; no completion is pending afterward.
- Outputs are Moore-decoded from the state register, except PCWrite/IRWrite in FETCH, which are qualified by mem_ready.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT (plus MULDIV with the optional feature).
- FETCH:
  - Drive mem_req=1, IorD=0, ALUsrcA=0, ALUsrcB=1, ALUOp=6'h20 (add).
  - Stall while mem_ready=0.
  - On mem_ready: IRWrite=1, PCWrite=1, PCSource=0, then go to DECODE.
- DECODE:
  - ALUsrcA=0, ALUsrcB=3, ALUOp=add (branch target to ALUOut).
  - Go to EXEC if opcode ∈ {0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x23, 0x2B}.
  - Otherwise pulse illegal and go to FETCH.
  - opcode 0 with func not in {0x20, 0x22, 0x24, 0x25, 0x2A, 0x08, 0x0C} is also illegal.
- EXEC:
  - R-type: ALUsrcA=1, ALUsrcB=0, ALUOp=func, then WB.
  - jr (func 0x08): PCWrite=1, PCSource=3, retire, then FETCH.
  - syscall (func 0x0C): retire, then HALT.
  - addi/lw/sw: ALUsrcB=2, ALUOp=add; addi goes to WB, lw/sw go to MEM.
  - beq/bne: ALUsrcA=1, ALUsrcB=0, ALUOp=6'h22 (sub). PCWrite=1, PCSource=1 when (zero XOR bne). Retire, then FETCH.
  - j: PCWrite=1, PCSource=2, retire, then FETCH.
  - jal: same as j plus jalCtrl=1 and RegWrite=1.
- MEM:
  - mem_req=1, IorD=1, MemWrite=(sw); hold until mem_ready.
  - sw retires and goes to FETCH; lw goes to WB.
- WB:
  - RegWrite=1 for one cycle; RegDest=(R-type); MemToReg=(lw).
  - Retire, then FETCH.
- HALT: absorbing until reset; halted=1; no mem_req.
- Cycle counts with mem_ready tied high: R-type/addi 4, lw 5, sw 4, branch/j/jal/jr 3.
- Each stall cycle on mem_ready=0 adds exactly one cycle.
- retired increments by 1 on the retiring cycle and wraps modulo 2^CNT_W. Illegal instructions do not retire.
- mem_ready asserted while mem_req=0 is ignored.

Optional Feature:
- Macro: MC_CU_MULDIV_EN.
- Defined:
  - func 0x18 (mult) and 0x1A (div) are legal.
  - EXEC enters MULDIV, which holds ALUOp=func for MULDIV_CYCLES cycles using a down-counter.
  - Then retire and go to FETCH, with RegWrite=0 (HI/LO updated internally by the ALU).
- Undefined: 0x18 and 0x1A decode as illegal.

Test Plan:
- Reset then add (op 0, func 0x20), mem_ready=1 -> RegWrite high in cycle 4 with RegDest=1; retired=1.
- lw (0x23) with mem_ready low 3 cycles in MEM -> 8 cycles total; WB has MemToReg=1; IorD=1 throughout MEM.
- beq with zero=1 -> PCWrite=1, PCSource=1 in cycle 3. bne with zero=1 -> PCWrite=0 in cycle 3. Both give retired +1.
- jal -> cycle 3 asserts PCWrite=1, PCSource=2, jalCtrl=1, RegWrite=1.
- opcode 0x3F -> illegal pulse in DECODE, next state FETCH, retired unchanged. syscall -> halted=1, mem_req stays 0 for 20 cycles.
- Assert rst_n=0 mid-MEM with mem_req=1 -> mem_req drops asynchronously. After release: FETCH, retired=0. Counter preset near max wraps to 0.
